// File: rtl/and_exer_pkg.sv
// Shared types and pattern helpers for the AND-unit built-in self-test.
// Operands are built at MAX_N bits and truncated to N by the user.
package and_exer_pkg;

  localparam int unsigned MAX_N = 64;

  typedef logic [MAX_N-1:0] opnd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Low n bits set.
  function automatic opnd_t all_ones(input int unsigned n);
    return (n >= MAX_N) ? '1 : ((opnd_t'(1) << n) - opnd_t'(1));
  endfunction

  // Operand a for pattern k: 0, ones, 0, ones, then a walking one.
  function automatic opnd_t pattern_a(input int unsigned k, input int unsigned n);
    if (k == 1 || k == 3) return all_ones(n);
    if (k >= 4) return opnd_t'(1) << (k - 4);
    return '0;
  endfunction

  // Operand b for pattern k: 0, 0, then ones for every later pattern.
  function automatic opnd_t pattern_b(input int unsigned k, input int unsigned n);
    return (k >= 2) ? all_ones(n) : '0;
  endfunction

  // Reference result of the unit under test.
  function automatic opnd_t expected(input opnd_t a, input opnd_t b);
    return a & b;
  endfunction

endpackage

// File: rtl/and_pattern_gen.sv
// Combinational pattern table: index k -> operands a, b and expected a & b.
// Ports:
//   k      in   pattern index
//   a_c    out  operand a for pattern k
//   b_c    out  operand b for pattern k
//   exp_c  out  expected AND result for pattern k
module and_pattern_gen
  import and_exer_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] k,
  output logic [N-1:0]     a_c,
  output logic [N-1:0]     b_c,
  output logic [N-1:0]     exp_c
);

  assign a_c   = N'(pattern_a(32'(k), N));
  assign b_c   = N'(pattern_b(32'(k), N));
  assign exp_c = N'(expected(pattern_a(32'(k), N), pattern_b(32'(k), N)));

endmodule

// File: rtl/and_vector_exerciser.sv
// Built-in self-test initiator for an N-bit bitwise-AND unit. On start it
// drives NPAT operand patterns, each held HOLD cycles, samples c_in on the
// last cycle of each hold and reports the outcome when the run ends.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (accepted only when idle)
//   a_out, b_out      registered operands to the AND unit
//   c_in              result from the AND unit
//   busy              high while the run is in progress
//   done              one-cycle pulse at the end of a run
//   pass              last run had no mismatches
//   err_count         mismatching patterns in the last run
//   first_fail        index of the first mismatching pattern (0 if none)
module and_vector_exerciser
  import and_exer_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned HOLD  = 10,
  localparam int unsigned NPAT  = 4 + N,
  localparam int unsigned CNT_W = $clog2(NPAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     a_out,
  output logic [N-1:0]     b_out,
  input  logic [N-1:0]     c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail
);

  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  ff_q, ff_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [CNT_W-1:0]  ld_k_c;
  logic [N-1:0]      ld_a_c, ld_b_c, ld_exp_c;

  // Index of the pattern to load next: P0 on start, otherwise P(k+1).
  assign ld_k_c = (state_q == IDLE) ? '0 : k_q + CNT_W'(1);

  and_pattern_gen #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_pattern_gen (
    .k     (ld_k_c),
    .a_c   (ld_a_c),
    .b_c   (ld_b_c),
    .exp_c (ld_exp_c)
  );

  // Next-state and output logic. The expected value is registered with
  // its operands so the compare never depends on the current index.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          hold_d  = '0;
          a_d     = ld_a_c;
          b_d     = ld_b_c;
          exp_d   = ld_exp_c;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(HOLD - 1)) begin
          // Operands have been stable for HOLD-1 full cycles here.
          if (c_in != exp_q) begin
            err_d = err_q + CNT_W'(1);
            if (err_q == '0) ff_d = k_q;
          end
          hold_d = '0;
          if (k_q == CNT_W'(NPAT - 1)) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = '0;
            b_d     = '0;
            exp_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            k_d   = k_q + CNT_W'(1);
            a_d   = ld_a_c;
            b_d   = ld_b_c;
            exp_d = ld_exp_c;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      hold_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_and_vector_exerciser.sv
// Scoreboard bench for and_vector_exerciser: stimulus pushes the expected
// operand sequence and run result, monitors pop and compare on the DUT's
// busy/done outputs. A second small instance covers N=1, HOLD=2.
module tb_and_vector_exerciser;

  localparam int unsigned N      = 4;
  localparam int unsigned HOLD   = 10;
  localparam int unsigned NPAT   = 4 + N;
  localparam int unsigned CNT_W  = $clog2(NPAT + 1);
  localparam int unsigned N1     = 1;
  localparam int unsigned HOLD1  = 2;
  localparam int unsigned NPAT1  = 4 + N1;
  localparam int unsigned CNT1_W = $clog2(NPAT1 + 1);

  typedef struct {
    int err;
    int ff;
    int pass;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   fault_mode = 0;

  logic [N-1:0]      a_out, b_out, c_in;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_count, first_fail;

  logic [N1-1:0]     a1, b1, c1;
  logic              busy1, done1, pass1;
  logic [CNT1_W-1:0] err1, ff1;

  int n_checks = 0;
  int n_fail   = 0;

  res_t         exp_q[$];
  res_t         exp1_q[$];
  logic [N-1:0] pa_q[$];
  logic [N-1:0] pb_q[$];

  always #5 clk = ~clk;

  // AND unit under test, with optional planted faults.
  always_comb begin
    if (fault_mode == 1)      c_in = (a_out & b_out) | N'(1);
    else if (fault_mode == 2) c_in = a_out | b_out;
    else                      c_in = a_out & b_out;
  end
  assign c1 = a1 & b1;

  and_vector_exerciser #(.N(N), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
    .c_in(c_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
  );

  and_vector_exerciser #(.N(N1), .HOLD(HOLD1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .c_in(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference operand table, written from the pattern description.
  function automatic logic [N-1:0] ref_a(input int k);
    if (k == 1 || k == 3) return {N{1'b1}};
    if (k >= 4) return N'(1 << (k - 4));
    return '0;
  endfunction

  function automatic logic [N-1:0] ref_b(input int k);
    return (k >= 2) ? {N{1'b1}} : '0;
  endfunction

  function automatic logic [N-1:0] unit_model(input int mode, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    if (mode == 1) return (a & b) | N'(1);
    if (mode == 2) return a | b;
    return a & b;
  endfunction

  // Push the operand sequence and run result the DUT should produce.
  task automatic expect_run(input int mode);
    res_t r;
    logic [N-1:0] a, b;
    r.err = 0;
    r.ff  = 0;
    for (int k = 0; k < int'(NPAT); k++) begin
      a = ref_a(k);
      b = ref_b(k);
      pa_q.push_back(a);
      pb_q.push_back(b);
      if (unit_model(mode, a, b) != (a & b)) begin
        if (r.err == 0) r.ff = k;
        r.err++;
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    exp_q.push_back(r);
  endtask

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic run_one(input int mode);
    fault_mode = mode;
    expect_run(mode);
    pulse_start();
    wait_done(int'(NPAT * HOLD) + 20);
    @(posedge clk); #1;
  endtask

  // Monitor for the main instance.
  initial begin : mon_main
    int unsigned busy_cnt = 0;
    res_t r;
    logic [N-1:0] pa, pb;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) begin
          if (busy_cnt % HOLD == 0) begin
            if (pa_q.size() == 0) begin
              fail_now("unexpected_pattern");
            end else begin
              pa = pa_q.pop_front();
              pb = pb_q.pop_front();
              check("a_out", int'(a_out), int'(pa));
              check("b_out", int'(b_out), int'(pb));
            end
          end
          busy_cnt++;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            r = exp_q.pop_front();
            check("err_count", int'(err_count), r.err);
            check("first_fail", int'(first_fail), r.ff);
            check("pass", int'(pass), r.pass);
            check("busy_cycles", int'(busy_cnt), int'(NPAT * HOLD));
            check("busy_at_done", int'(busy), 0);
            check("a_out_at_done", int'(a_out), 0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Monitor for the N=1 instance.
  initial begin : mon_small
    int unsigned busy_cnt = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy1) busy_cnt++;
        if (done1) begin
          if (exp1_q.size() == 0) begin
            fail_now("unexpected_done_n1");
          end else begin
            r = exp1_q.pop_front();
            check("err_count_n1", int'(err1), r.err);
            check("first_fail_n1", int'(ff1), r.ff);
            check("pass_n1", int'(pass1), r.pass);
            check("busy_cycles_n1", int'(busy_cnt), int'(NPAT1 * HOLD1));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    res_t r1;
    int nd, prev_cyc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_a_out", int'(a_out), 0);
    check("rst_b_out", int'(b_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_first_fail", int'(first_fail), 0);

    // Ideal unit, stuck-at-1 on bit 0, and an OR gate in its place.
    run_one(0);
    run_one(1);
    run_one(2);
    repeat (3) @(posedge clk);
    #1;
    check("results_stable_err", int'(err_count), 6);
    check("results_stable_ff", int'(first_fail), 1);

    // Reset 35 cycles into a run: abort without a done pulse.
    fault_mode = 0;
    expect_run(0);
    pulse_start();
    repeat (34) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    pa_q.delete();
    pb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_a_out", int'(a_out), 0);
    check("abort_b_out", int'(b_out), 0);
    check("abort_err_count", int'(err_count), 0);
    check("abort_done", int'(done), 0);
    run_one(0);

    // Extra starts during RUN and in FINISH are ignored.
    expect_run(0);
    pulse_start();
    repeat (19) @(posedge clk);
    #1;
    pulse_start();
    repeat (58) @(posedge clk);
    #1;
    pulse_start();
    wait_done(20);
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    check("idle_after_ignored_starts", int'(busy), 0);

    // start held high for 200 cycles: back-to-back runs every 82 cycles.
    repeat (3) expect_run(0);
    start = 1'b1;
    nd = 0;
    prev_cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 200) start = 1'b0;
      if (done) begin
        if (nd > 0) check("done_period", i - prev_cyc, 82);
        prev_cyc = i;
        nd++;
      end
    end
    check("held_start_runs", nd, 3);

    // Randomized runs with random fault mode and idle gap.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
      run_one(int'($urandom_range(0, 2)));
    end
    fault_mode = 0;

    // N=1, HOLD=2 instance with an ideal unit.
    r1.err  = 0;
    r1.ff   = 0;
    r1.pass = 1;
    exp1_q.push_back(r1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk); #1;
        if (done1) seen = 1'b1;
      end
      if (!seen) fail_now("done_timeout_n1");
    end

    repeat (20) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("pat_q_drained", pa_q.size(), 0);
    check("exp1_q_drained", exp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
